// File: rtl/router_vc_buffer_pkg.sv
// Shared types and constants for the router virtual-channel input buffer.
// Framing state encoding and error-cause bit positions.
package router_vc_buffer_pkg;

   typedef enum logic {
      FRAME_IDLE      = 1'b0,
      FRAME_IN_PACKET = 1'b1
   } frame_state_t;

   localparam int ERR_W             = 3;
   localparam int ERR_IDX_OVERFLOW  = 0;
   localparam int ERR_IDX_UNDERFLOW = 1;
   localparam int ERR_IDX_FRAMING   = 2;

endpackage

// File: rtl/router_vc_buffer_vc_fifo.sv
// One virtual channel: circular flit store, pointers, occupancy and packet framing FSM.
//
// state           | meaning
// FRAME_IDLE      | between packets, next accepted flit should be a head
// FRAME_IN_PACKET | head seen without tail, body/tail flits expected
module vc_fifo
   import router_vc_buffer_pkg::*;
#(
   parameter int buffer_depth    = 8,
   parameter int flit_data_width = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_req,
   input  logic                       wr_head,
   input  logic                       wr_tail,
   input  logic [flit_data_width-1:0] wr_data,
   input  logic                       pop_req,
   output logic [flit_data_width-1:0] rd_data,
   output logic                       rd_head,
   output logic                       rd_tail,
   output logic                       nonempty,
   output logic                       pop_ok,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       framing_err
);
   localparam int ptr_w = $clog2(buffer_depth);
   localparam int occ_w = ptr_w + 1;
   localparam logic [occ_w-1:0] occ_full = occ_w'(buffer_depth);

   logic [flit_data_width+1:0] mem [buffer_depth];
   logic [ptr_w-1:0]           wr_ptr;
   logic [ptr_w-1:0]           rd_ptr;
   logic [occ_w-1:0]           occ;
   frame_state_t               state;
   frame_state_t               state_nxt;
   logic                       full;
   logic                       empty;
   logic                       wr_ok;

   assign full      = (occ == occ_full);
   assign empty     = (occ == '0);
   assign pop_ok    = pop_req && !empty;
   // a pop of the same full VC frees the slot this write lands in
   assign wr_ok     = wr_req && (!full || pop_ok);
   assign overflow  = wr_req && !wr_ok;
   assign underflow = pop_req && empty;
   assign nonempty  = !empty;
   assign {rd_head, rd_tail, rd_data} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + ptr_w'(1);
         if (wr_ok && !pop_ok)
            occ <= occ + occ_w'(1);
         else if (pop_ok && !wr_ok)
            occ <= occ - occ_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !reset)
         mem[wr_ptr] <= {wr_head, wr_tail, wr_data};
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= FRAME_IDLE;
      else
         state <= state_nxt;
   end

   // a head always restarts framing as if idle, even mid-packet
   always_comb begin
      state_nxt = state;
      if (wr_ok) begin
         if (wr_head)
            state_nxt = wr_tail ? FRAME_IDLE : FRAME_IN_PACKET;
         else if ((state == FRAME_IN_PACKET) && wr_tail)
            state_nxt = FRAME_IDLE;
      end
   end

   always_comb begin
      framing_err = 1'b0;
      if (wr_ok) begin
         case (state)
            FRAME_IDLE:      framing_err = !wr_head;
            FRAME_IN_PACKET: framing_err = wr_head;
            default:         framing_err = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/router_vc_buffer.sv
// Router input port buffer: per-VC flit FIFOs, read mux, credit return and error flag.
// Define ROUTER_VC_BUFFER_ERROR_CAPTURE_EN to make error_out sticky until reset.
module router_vc_buffer
   import router_vc_buffer_pkg::*;
#(
   parameter int num_vcs         = 4,
   parameter int buffer_depth    = 8,
   parameter int flit_data_width = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flit_valid_in,
   input  logic                       flit_head_in,
   input  logic                       flit_tail_in,
   input  logic [$clog2(num_vcs)-1:0] flit_vc_in,
   input  logic [flit_data_width-1:0] flit_data_in,
   input  logic                       pop_in,
   input  logic [$clog2(num_vcs)-1:0] pop_vc_in,
   output logic [flit_data_width-1:0] rd_data_out,
   output logic                       rd_head_out,
   output logic                       rd_tail_out,
   output logic [num_vcs-1:0]         vc_nonempty_out,
   output logic                       credit_valid_out,
   output logic [$clog2(num_vcs)-1:0] credit_vc_out,
   output logic                       error_out
);
   localparam int vcw = $clog2(num_vcs);

   logic [flit_data_width-1:0] vc_rd_data [num_vcs];
   logic [num_vcs-1:0]         vc_rd_head;
   logic [num_vcs-1:0]         vc_rd_tail;
   logic [num_vcs-1:0]         vc_pop_ok;
   logic [num_vcs-1:0]         vc_overflow;
   logic [num_vcs-1:0]         vc_underflow;
   logic [num_vcs-1:0]         vc_framing;
   logic [ERR_W-1:0]           err_cause;

   for (genvar v = 0; v < num_vcs; v++) begin : g_vc
      logic sel_wr;
      logic sel_pop;

      assign sel_wr  = flit_valid_in && (flit_vc_in == vcw'(v));
      assign sel_pop = pop_in && (pop_vc_in == vcw'(v));

      vc_fifo #(
         .buffer_depth    (buffer_depth),
         .flit_data_width (flit_data_width)
      ) u_vc_fifo (
         .clk         (clk),
         .reset       (reset),
         .wr_req      (sel_wr),
         .wr_head     (flit_head_in),
         .wr_tail     (flit_tail_in),
         .wr_data     (flit_data_in),
         .pop_req     (sel_pop),
         .rd_data     (vc_rd_data[v]),
         .rd_head     (vc_rd_head[v]),
         .rd_tail     (vc_rd_tail[v]),
         .nonempty    (vc_nonempty_out[v]),
         .pop_ok      (vc_pop_ok[v]),
         .overflow    (vc_overflow[v]),
         .underflow   (vc_underflow[v]),
         .framing_err (vc_framing[v])
      );
   end

   always_comb begin
      rd_data_out = '0;
      rd_head_out = 1'b0;
      rd_tail_out = 1'b0;
      for (int v = 0; v < num_vcs; v++) begin
         if (pop_vc_in == vcw'(v)) begin
            rd_data_out = vc_rd_data[v];
            rd_head_out = vc_rd_head[v];
            rd_tail_out = vc_rd_tail[v];
         end
      end
   end

   always_comb begin
      err_cause                    = '0;
      err_cause[ERR_IDX_OVERFLOW]  = |vc_overflow;
      err_cause[ERR_IDX_UNDERFLOW] = |vc_underflow;
      err_cause[ERR_IDX_FRAMING]   = |vc_framing;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         credit_valid_out <= 1'b0;
         credit_vc_out    <= '0;
         error_out        <= 1'b0;
      end else begin
         credit_valid_out <= |vc_pop_ok;
         credit_vc_out    <= pop_vc_in;
`ifdef ROUTER_VC_BUFFER_ERROR_CAPTURE_EN
         error_out        <= error_out | (|err_cause);
`else
         error_out        <= |err_cause;
`endif
      end
   end

endmodule

// File: tb/tb_router_vc_buffer.sv
// Scoreboard bench for router_vc_buffer: directed scenarios then random traffic,
// checked every cycle against a flat-queue reference model of the buffer.
module tb_router_vc_buffer;
   localparam int NV    = 4;
   localparam int DEPTH = 8;
   localparam int W     = 32;
   localparam int VCW   = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           flit_valid_in;
   logic           flit_head_in;
   logic           flit_tail_in;
   logic [VCW-1:0] flit_vc_in;
   logic [W-1:0]   flit_data_in;
   logic           pop_in;
   logic [VCW-1:0] pop_vc_in;
   logic [W-1:0]   rd_data_out;
   logic           rd_head_out;
   logic           rd_tail_out;
   logic [NV-1:0]  vc_nonempty_out;
   logic           credit_valid_out;
   logic [VCW-1:0] credit_vc_out;
   logic           error_out;

   router_vc_buffer #(.num_vcs(NV), .buffer_depth(DEPTH), .flit_data_width(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .flit_valid_in    (flit_valid_in),
      .flit_head_in     (flit_head_in),
      .flit_tail_in     (flit_tail_in),
      .flit_vc_in       (flit_vc_in),
      .flit_data_in     (flit_data_in),
      .pop_in           (pop_in),
      .pop_vc_in        (pop_vc_in),
      .rd_data_out      (rd_data_out),
      .rd_head_out      (rd_head_out),
      .rd_tail_out      (rd_tail_out),
      .vc_nonempty_out  (vc_nonempty_out),
      .credit_valid_out (credit_valid_out),
      .credit_vc_out    (credit_vc_out),
      .error_out        (error_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [VCW-1:0] vc;
      logic           head;
      logic           tail;
      logic [W-1:0]   data;
   } flit_t;

   typedef struct {
      bit            err;
      logic [NV-1:0] nonempty;
      bit            credit;
      int            credit_vc;
      bit            rd_valid;
      flit_t         rd;
   } exp_t;

   // every stored flit, in arrival order; a VC's front is its oldest entry
   flit_t sb_flits[$];
   exp_t  exp_q[$];
   bit    in_pkt [NV];
   bit    err_level;
   int    checks = 0;
   int    errors = 0;
   int    credits_seen = 0;

   function automatic int vc_count(input int v);
      int n = 0;
      foreach (sb_flits[i]) if (int'(sb_flits[i].vc) == v) n++;
      return n;
   endfunction

   function automatic int vc_front(input int v);
      foreach (sb_flits[i]) if (int'(sb_flits[i].vc) == v) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   task automatic step(input bit rst, input bit v, input bit h, input bit t, input int wvc,
                       input logic [W-1:0] d, input bit p, input int pvc);
      exp_t  e;
      flit_t f;
      int    idx;
      bit    pop_ok;
      bit    wr_ok;
      bit    evt;
      @(negedge clk);
      reset         = rst;
      flit_valid_in = v;
      flit_head_in  = h;
      flit_tail_in  = t;
      flit_vc_in    = VCW'(wvc);
      flit_data_in  = d;
      pop_in        = p;
      pop_vc_in     = VCW'(pvc);
      e.credit      = 1'b0;
      e.credit_vc   = pvc;
      if (rst) begin
         sb_flits.delete();
         foreach (in_pkt[i]) in_pkt[i] = 1'b0;
         err_level = 1'b0;
      end else begin
         evt    = 1'b0;
         pop_ok = p && (vc_count(pvc) > 0);
         if (p && !pop_ok) evt = 1'b1;
         wr_ok = v && ((vc_count(wvc) < DEPTH) || (pop_ok && pvc == wvc));
         if (v && !wr_ok) evt = 1'b1;
         if (pop_ok) sb_flits.delete(vc_front(pvc));
         if (wr_ok) begin
            if (in_pkt[wvc] ? h : !h) evt = 1'b1;
            in_pkt[wvc] = in_pkt[wvc] ? !t : (h && !t);
            f.vc = VCW'(wvc); f.head = h; f.tail = t; f.data = d;
            sb_flits.push_back(f);
         end
         e.credit = pop_ok;
`ifdef ROUTER_VC_BUFFER_ERROR_CAPTURE_EN
         err_level = err_level | evt;
`else
         err_level = evt;
`endif
      end
      e.err = err_level;
      for (int i = 0; i < NV; i++) e.nonempty[i] = (vc_count(i) > 0);
      idx = vc_front(pvc);
      e.rd_valid = (idx >= 0);
      e.rd = (idx >= 0) ? sb_flits[idx] : '0;
      exp_q.push_back(e);
   endtask

   task automatic wr(input int vc, input logic [W-1:0] d);
      step(0, 1, 1, 1, vc, d, 0, 0);
   endtask

   task automatic pop(input int vc);
      step(0, 0, 0, 0, 0, '0, 1, vc);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, '0, 0, 0);
   endtask

   // monitor: consumes one expectation per driven cycle, just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (credit_valid_out === 1'b1) credits_seen++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vc_nonempty", 64'(vc_nonempty_out), 64'(e.nonempty));
            chk("error_out", 64'(error_out), 64'(e.err));
            chk("credit_valid", 64'(credit_valid_out), 64'(e.credit));
            if (e.credit) chk("credit_vc", 64'(credit_vc_out), 64'(e.credit_vc));
            if (e.rd_valid)
               chk("rd_flit", {30'b0, rd_head_out, rd_tail_out, rd_data_out},
                   {30'b0, e.rd.head, e.rd.tail, e.rd.data});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int wrote;
      int popped;
      int base;
      bit do_w;
      bit do_p;
      step(1, 0, 0, 0, 0, '0, 0, 0);
      step(1, 0, 0, 0, 0, '0, 0, 0);
      idle();

      // VC2 filled to depth, ninth write dropped
      for (int i = 0; i < DEPTH + 1; i++) wr(2, 32'h200 + 32'(i));
      idle();
      for (int i = 0; i < DEPTH; i++) pop(2);
      idle();

      // VC1 full, write and pop together
      for (int i = 0; i < DEPTH; i++) wr(1, 32'h100 + 32'(i));
      step(0, 1, 1, 1, 1, 32'h1ff, 1, 1);
      idle();
      for (int i = 0; i < DEPTH; i++) pop(1);
      idle();

      // pop of empty VC0 while writing VC0, then write X / pop Y
      step(0, 1, 1, 1, 0, 32'hABCD, 1, 0);
      idle();
      step(0, 1, 1, 1, 3, 32'h3333, 1, 0);
      pop(3);
      idle();

      // VC3 framing: head, body, head (error), tail, then single-flit packet
      step(0, 1, 1, 0, 3, 32'h31, 0, 3);
      step(0, 1, 0, 0, 3, 32'h32, 0, 3);
      step(0, 1, 1, 0, 3, 32'h33, 0, 3);
      step(0, 1, 0, 1, 3, 32'h34, 0, 3);
      step(0, 1, 1, 1, 3, 32'h35, 0, 3);
      idle();
      for (int i = 0; i < 5; i++) pop(3);
      idle();

      // VC0 mid-fill then reset with a concurrent write and pop
      step(0, 1, 1, 0, 0, 32'h50, 0, 0);
      for (int i = 1; i < 5; i++) step(0, 1, 0, 0, 0, 32'h50 + 32'(i), 0, 0);
      step(1, 1, 1, 1, 0, 32'h5f, 1, 0);
      idle();
      pop(0);
      idle();

      // 20 flits through VC1 with interleaved pops, wrapping the pointers
      wrote  = 0;
      popped = 0;
      base   = credits_seen;
      while (popped < 20) begin
         do_w = (wrote < 20);
         do_p = (vc_count(1) > 0) && (wrote >= 3 || !do_w);
         step(0, do_w, 1, 1, 1, 32'h4000 + 32'(wrote), do_p, 1);
         wrote  += int'(do_w);
         popped += int'(do_p);
      end
      idle();
      idle();
      chk("vc1_stream_credits", 64'(credits_seen - base), 64'd20);

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
              1'($urandom), int'($urandom_range(NV - 1)), $urandom,
              ($urandom_range(2) != 0), int'($urandom_range(NV - 1)));
      end
      idle();
      idle();
      idle();
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/router_vc_buffer.md
ROUTER_VC_BUFFER -- requirements
Module: router_vc_buffer

Interface
REQ-001 SHALL have parameter num_vcs, default 4, number of virtual channels (>=2).
REQ-002 SHALL have parameter buffer_depth, default 8, flits per VC (power of two, >=2).
REQ-003 SHALL have parameter flit_data_width, default 32, payload bits per flit.
REQ-004 SHALL have ports as follows; vcw = clog2(num_vcs); one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 flit_valid_in  input  1  flit present this cycle.
REQ-008 flit_head_in / flit_tail_in  input  1 each  head and tail markers.
REQ-009 flit_vc_in  input  vcw  target VC of incoming flit.
REQ-010 flit_data_in  input  flit_data_width  payload.
REQ-011 pop_in  input  1  remove front flit of VC pop_vc_in.
REQ-012 pop_vc_in  input  vcw  VC selected for read and pop.
REQ-013 rd_data_out / rd_head_out / rd_tail_out  output  flit_data_width / 1 / 1  front flit of pop_vc_in, combinational.
REQ-014 vc_nonempty_out  output  num_vcs  bit v high when VC v occupancy > 0.
REQ-015 credit_valid_out / credit_vc_out  output  1 / vcw  registered credit return.
REQ-016 error_out  output  1  protocol error indication.

Function
REQ-017 SHALL keep one circular FIFO per VC with write pointer, read pointer, occupancy counter 0..buffer_depth (clog2(buffer_depth)+1 bits); pointers wrap modulo buffer_depth.
REQ-018 Valid flit to VC not full SHALL be written at the edge; visible on rd_* and vc_nonempty_out next cycle (no same-cycle bypass).
REQ-019 Valid flit to full VC with no simultaneous pop of that VC SHALL be dropped and flag overflow error.
REQ-020 Write and pop of same full VC in one cycle SHALL both occur, occupancy unchanged, no error.
REQ-021 pop_in on empty VC SHALL change nothing for that VC and flag underflow error; a same-cycle write to that VC SHALL still be accepted.
REQ-022 Each accepted pop SHALL produce credit_valid_out=1, credit_vc_out=pop_vc_in exactly one cycle later; otherwise credit_valid_out=0.
REQ-023 Each VC SHALL have framing state machine IDLE/IN_PACKET, updated only by accepted flits.
REQ-024 IDLE: head&tail -> IDLE; head&!tail -> IN_PACKET; non-head -> framing error, flit still stored, stay IDLE.
REQ-025 IN_PACKET: tail&!head -> IDLE; !head&!tail -> IN_PACKET; any head -> framing error, flit stored, state per REQ-024 as if IDLE.
REQ-026 Errors (overflow, underflow, framing) SHALL be registered; error_out asserts cycle after the offending edge.
REQ-027 Different VCs SHALL operate independently; write VC X and pop VC Y same cycle both proceed.

Reset
REQ-028 On reset high at an edge: all pointers and occupancies 0, framing IDLE, credit_valid_out 0, error_out 0; vc_nonempty_out all 0 next cycle.
REQ-029 Reset mid-packet SHALL discard all stored flits and issue no credits for them; reset dominates same-cycle write/pop.
REQ-030 Buffer storage array SHALL NOT require reset.

Configuration
REQ-031 With ROUTER_VC_BUFFER_ERROR_CAPTURE_EN defined, error_out SHALL be sticky, cleared only by reset.
REQ-032 Without it, error_out SHALL be a one-cycle pulse per cycle containing any error event.

Structure
REQ-033 Shared package SHALL hold framing state encoding (IDLE=0, IN_PACKET=1) and error-cause constants.
REQ-034 A sub-module vc_fifo (one VC: storage, pointers, occupancy, framing FSM) SHALL be instantiated num_vcs times; top holds demux, read mux, credit and error registers.

Verification
REQ-035 Write 8 flits to VC2 (depth 8), 9th write -> dropped, error_out=1 next cycle, occupancy stays 8.
REQ-036 VC1 full, write+pop VC1 same cycle -> occupancy 8, no error, credit_vc_out=1 next cycle.
REQ-037 Pop empty VC0 while writing VC0 -> error_out=1, no credit, vc_nonempty_out[0]=1 next cycle.
REQ-038 VC3 head(no tail), body, head -> framing error on second head; head+tail single flit -> no error.
REQ-039 Fill VC0 to 5, assert reset -> all vc_nonempty_out 0, no credits, error_out 0.
REQ-040 Write 20 flits/pop 20 on VC1 interleaved -> data order preserved across pointer wrap, 20 credits returned.
